lut_eval_seq: RTL

- Parametrised, registered successor to the fixed 4-input sum-of-products lab function.
- Holds an N_IN-input Boolean function as a loadable truth table.
- Evaluates single input vectors with one-cycle latency.
- Sweep mode streams the full truth table and counts its minterms.
- Sits between lab stimulus logic (switches/testbench) and display/checker logic.

---
 rtl/lut_eval_pkg.sv | 17 +
 rtl/lut_eval_if.sv | 32 +++
 rtl/lut_eval_seq_mux.sv | 14 +
 rtl/lut_eval_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/lut_eval_pkg.sv
// Shared types and limits for the truth-table evaluator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lut_eval_pkg;

  // Supported range of function input counts.
  localparam int MIN_N_IN = 2;
  localparam int MAX_N_IN = 8;

  // Controller states: idle/evaluate, streaming sweep, one-cycle wrap-up.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/lut_eval_if.sv
// Request/response bundle between stimulus logic and the truth-table evaluator.
// Latency: n/a (wiring only).
// Backpressure: none; requests are dropped while busy is high.
interface lut_eval_if #(
  parameter int N_IN = 4
);

  logic                 cfg_load;
  logic [2**N_IN-1:0]   cfg_table;
  logic                 in_valid;
  logic [N_IN-1:0]      in_vec;
  logic                 sweep_start;
  logic                 out_valid;
  logic [N_IN-1:0]      out_idx;
  logic                 y;
  logic                 busy;
  logic                 done;
  logic [N_IN:0]        ones_count;

  // Stimulus side: issues configuration, evaluation and sweep requests.
  modport master (
    output cfg_load, cfg_table, in_valid, in_vec, sweep_start,
    input  out_valid, out_idx, y, busy, done, ones_count
  );

  // Evaluator side.
  modport slave (
    input  cfg_load, cfg_table, in_valid, in_vec, sweep_start,
    output out_valid, out_idx, y, busy, done, ones_count
  );

endinterface

// File: rtl/lut_eval_seq_mux.sv
// Combinational 2**N_IN:1 select of one truth-table bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module lut_mux #(
  parameter int N_IN = 4
) (
  input  logic [2**N_IN-1:0] table_bits,
  input  logic [N_IN-1:0]    sel,
  output logic               bit_out
);

  assign bit_out = table_bits[sel];

endmodule

// File: rtl/lut_eval_seq.sv
// Loadable N_IN-input truth table with single-vector evaluation and full-table sweep.
// Latency: 1 cycle per evaluation; a sweep streams 2**N_IN outputs starting 2 cycles after start.
// Backpressure: none; all requests are ignored while busy (sweep or its wrap-up cycle).
module lut_eval_seq
  import lut_eval_pkg::*;
#(
  parameter int                 N_IN       = 4,
  parameter logic [2**N_IN-1:0] INIT_TABLE = 16'hA7FF
) (
  input  logic       clk,
  input  logic       rst_n,
  lut_eval_if.slave  bus
);

  localparam int DEPTH = 2**N_IN;

  if (N_IN < MIN_N_IN || N_IN > MAX_N_IN) begin : g_bad_n_in
    $error("lut_eval_seq: N_IN out of supported range");
  end

  state_t              state;
  logic [N_IN-1:0]     idx;
  logic [DEPTH-1:0]    lut_table;
  logic [N_IN-1:0]     sel;
  logic                sel_bit;

  logic                out_valid_q;
  logic [N_IN-1:0]     out_idx_q;
  logic                y_q;
  logic                busy_q;
  logic                done_q;
  logic [N_IN:0]       ones_count_q;

  // One shared table read port: the sweep index owns it during a sweep, the request vector otherwise.
  always_comb begin
    sel = bus.in_vec;
    if (state == SWEEP) begin
      sel = idx;
    end
  end

  lut_mux #(
    .N_IN(N_IN)
  ) u_mux (
    .table_bits (lut_table),
    .sel        (sel),
    .bit_out    (sel_bit)
  );

  // Controller: table updates, evaluation responses, sweep sequencing and minterm counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      lut_table    <= INIT_TABLE;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      y_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ones_count_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          // The read above sees the pre-edge table, so a same-cycle eval uses the old contents,
          // while a same-cycle sweep starts reading next cycle and sees the new contents.
          if (bus.cfg_load) begin
            lut_table <= bus.cfg_table;
          end
          if (bus.sweep_start) begin
            state        <= SWEEP;
            idx          <= '0;
            ones_count_q <= '0;
            busy_q       <= 1'b1;
          end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= bus.in_vec;
            y_q         <= sel_bit;
          end
        end
        SWEEP: begin
          out_valid_q  <= 1'b1;
          out_idx_q    <= idx;
          y_q          <= sel_bit;
          ones_count_q <= ones_count_q + {{N_IN{1'b0}}, sel_bit};
          idx          <= idx + {{(N_IN-1){1'b0}}, 1'b1};
          // Terminal compare on all-ones; the index wraps to zero harmlessly afterwards.
          if (idx == {N_IN{1'b1}}) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.y          = y_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ones_count = ones_count_q;

endmodule
